// File: rtl/any1_pkg.sv
// Shared definitions for the any1 load alignment path: load size codes,
// the alignment FSM state type and the byte-lane select helper.
package any1_pkg;

    // Load size codes carried in func[2:0]; func[3] selects zero-extension.
    localparam logic [2:0] LDSZ_BYTE  = 3'd0;
    localparam logic [2:0] LDSZ_WYDE  = 3'd1;
    localparam logic [2:0] LDSZ_TETRA = 3'd2;
    localparam logic [2:0] LDSZ_OCTA  = 3'd3;
    localparam logic [2:0] LDSZ_HEXI  = 3'd4;

    // Width of one bus beat in bytes.
    localparam logic [5:0] BEAT_BYTES = 6'd32;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        DONE
    } e_ldalign_state;

    // Byte count for a size code; illegal codes return zero so that any
    // span computed from them is harmless (they never reach the bus).
    function automatic logic [5:0] ldbytes(input logic [2:0] size);
        logic [5:0] n;
        case (size)
            LDSZ_BYTE:  n = 6'd1;
            LDSZ_WYDE:  n = 6'd2;
            LDSZ_TETRA: n = 6'd4;
            LDSZ_OCTA:  n = 6'd8;
            LDSZ_HEXI:  n = 6'd16;
            default:    n = 6'd0;
        endcase
        return n;
    endfunction

    // Lane mask for one beat of an access of n bytes starting at lane off.
    // Beat 0 covers lanes off..min(off+n,32)-1, beat 1 covers the lanes
    // that spill past the end of the first line, i.e. 0..off+n-33.
    function automatic logic [31:0] ldsel(input logic [4:0] off,
                                          input logic [5:0] n,
                                          input logic       beat);
        logic [5:0]  span;
        logic [31:0] mask;
        span = {1'b0, off} + n;
        mask = '0;
        for (int i = 0; i < 32; i++) begin
            if (!beat) begin
                mask[i] = (6'(i) >= {1'b0, off}) && (6'(i) < span);
            end else begin
                mask[i] = (6'(i) + BEAT_BYTES) < span;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/any1_load_extend.sv
// Combinational lane extractor: shifts the two-beat read window down to the
// addressed byte, keeps the access width and sign- or zero-extends it to
// 128 bits. Hexi loads fill the full result, so the unsigned flag is moot.
module any1_load_extend
    import any1_pkg::*;
(
    input  logic [511:0] pair,
    input  logic [4:0]   off,
    input  logic [2:0]   size,
    input  logic         uns,
    output logic [127:0] dat
);

    logic [127:0] win;
    logic [8:0]   shamt;

    assign shamt = {off, 3'b000};

    // Extract the addressed window and extend from the access's top bit.
    always_comb begin
        win = 128'(pair >> shamt);
        dat = '0;
        case (size)
            LDSZ_BYTE:  dat = {{120{win[7]  & ~uns}}, win[7:0]};
            LDSZ_WYDE:  dat = {{112{win[15] & ~uns}}, win[15:0]};
            LDSZ_TETRA: dat = {{96{win[31]  & ~uns}}, win[31:0]};
            LDSZ_OCTA:  dat = {{64{win[63]  & ~uns}}, win[63:0]};
            LDSZ_HEXI:  dat = win;
            default:    dat = '0;
        endcase
    end

endmodule

// File: rtl/any1_load_align.sv
// Load alignment unit: accepts a decoded load, runs one or two 256-bit bus
// read beats with the right lane selects, and returns the aligned, extended
// 128-bit result through a valid/ready handshake.
// Build option: ANY1_LDALIGN_SPLIT_EN enables line-crossing loads (second
// beat); without it a line-crossing load completes immediately with an error.
module any1_load_align
    import any1_pkg::*;
#(
    parameter int AWID = 32,
    parameter int TAGW = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [3:0]      req_func_i,
    input  logic [AWID-1:0] req_adr_i,
    input  logic [TAGW-1:0] req_tag_i,
    output logic            bus_cyc_o,
    output logic [AWID-1:0] bus_adr_o,
    output logic [31:0]     bus_sel_o,
    input  logic            bus_ack_i,
    input  logic            bus_err_i,
    input  logic [255:0]    bus_dat_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [127:0]    res_dat_o,
    output logic            res_err_o,
    output logic [TAGW-1:0] res_tag_o
);

    e_ldalign_state state_q, state_d;

    logic [3:0]      func_q;
    logic [AWID-1:0] adr_q;
    logic [TAGW-1:0] tag_q;

    logic [127:0]    res_dat_q;
    logic            res_err_q;
    logic [TAGW-1:0] res_tag_q;

    logic            req_take;
    logic            res_load;
    logic            res_fault;
    logic [TAGW-1:0] res_tag_d;
    logic            beat0_cap;

    logic [5:0]      req_n;
    logic [5:0]      req_span;
    logic            req_bad;

    logic [4:0]      off_q;
    logic [5:0]      n_q;
    logic [5:0]      span_q;
    logic [AWID-1:0] line_adr;

    logic [511:0]    pair;
    logic [127:0]    ext_dat;

`ifdef ANY1_LDALIGN_SPLIT_EN
    logic [255:0]    beat0_q;
`endif

    // Decode of the incoming request, used only while idle.
    assign req_n    = ldbytes(req_func_i[2:0]);
    assign req_span = {1'b0, req_adr_i[4:0]} + req_n;
`ifdef ANY1_LDALIGN_SPLIT_EN
    assign req_bad  = (req_func_i[2:0] > LDSZ_HEXI);
`else
    assign req_bad  = (req_func_i[2:0] > LDSZ_HEXI) || (req_span > BEAT_BYTES);
`endif

    // Decode of the latched request that drives the bus beats.
    assign off_q    = adr_q[4:0];
    assign n_q      = ldbytes(func_q[2:0]);
    assign span_q   = {1'b0, off_q} + n_q;
    assign line_adr = {adr_q[AWID-1:5], 5'b00000};

    // The result loads on the same edge that samples the final ack, so the
    // last beat comes straight from the bus and only beat 0 needs storage.
`ifdef ANY1_LDALIGN_SPLIT_EN
    assign pair = (state_q == BEAT1) ? {bus_dat_i, beat0_q} : {256'b0, bus_dat_i};
`else
    assign pair = {256'b0, bus_dat_i};
`endif

    any1_load_extend u_extend (
        .pair (pair),
        .off  (off_q),
        .size (func_q[2:0]),
        .uns  (func_q[3]),
        .dat  (ext_dat)
    );

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus bus and handshake outputs. Error beats take
    // priority over ack, and bus responses outside a beat state are ignored.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        req_take    = 1'b0;
        bus_cyc_o   = 1'b0;
        bus_adr_o   = '0;
        bus_sel_o   = '0;
        res_valid_o = 1'b0;
        res_load    = 1'b0;
        res_fault   = 1'b0;
        res_tag_d   = tag_q;
        beat0_cap   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    req_take = 1'b1;
                    if (req_bad) begin
                        state_d   = DONE;
                        res_load  = 1'b1;
                        res_fault = 1'b1;
                        res_tag_d = req_tag_i;
                    end else begin
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0: begin
                bus_cyc_o = 1'b1;
                bus_adr_o = line_adr;
                bus_sel_o = ldsel(off_q, n_q, 1'b0);
                if (bus_err_i) begin
                    state_d   = DONE;
                    res_load  = 1'b1;
                    res_fault = 1'b1;
                end else if (bus_ack_i) begin
`ifdef ANY1_LDALIGN_SPLIT_EN
                    if (span_q > BEAT_BYTES) begin
                        state_d   = BEAT1;
                        beat0_cap = 1'b1;
                    end else begin
                        state_d  = DONE;
                        res_load = 1'b1;
                    end
`else
                    state_d  = DONE;
                    res_load = 1'b1;
`endif
                end
            end
`ifdef ANY1_LDALIGN_SPLIT_EN
            BEAT1: begin
                bus_cyc_o = 1'b1;
                bus_adr_o = line_adr + AWID'(BEAT_BYTES);
                bus_sel_o = ldsel(off_q, n_q, 1'b1);
                if (bus_err_i) begin
                    state_d   = DONE;
                    res_load  = 1'b1;
                    res_fault = 1'b1;
                end else if (bus_ack_i) begin
                    state_d  = DONE;
                    res_load = 1'b1;
                end
            end
`endif
            DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch: captured once on accept and held for the whole load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            func_q <= '0;
            adr_q  <= '0;
            tag_q  <= '0;
        end else if (req_take) begin
            func_q <= req_func_i;
            adr_q  <= req_adr_i;
            tag_q  <= req_tag_i;
        end
    end

`ifdef ANY1_LDALIGN_SPLIT_EN
    // First-beat holding register for line-crossing loads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat0_q <= '0;
        end else if (beat0_cap) begin
            beat0_q <= bus_dat_i;
        end
    end
`endif

    // Result registers: loaded when the final beat or a fault is seen, then
    // held untouched while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_dat_q <= '0;
            res_err_q <= 1'b0;
            res_tag_q <= '0;
        end else if (res_load) begin
            res_dat_q <= res_fault ? '0 : ext_dat;
            res_err_q <= res_fault;
            res_tag_q <= res_tag_d;
        end
    end

    assign res_dat_o = res_dat_q;
    assign res_err_o = res_err_q;
    assign res_tag_o = res_tag_q;

endmodule

// File: tb/tb_any1_load_align.sv
// Directed testbench for any1_load_align. Expected values are hand-derived;
// the line-crossing case expects either a two-beat load or an immediate
// error depending on ANY1_LDALIGN_SPLIT_EN.
module tb_any1_load_align;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [3:0]   req_func_i;
    logic [31:0]  req_adr_i;
    logic [5:0]   req_tag_i;
    logic         bus_cyc_o;
    logic [31:0]  bus_adr_o;
    logic [31:0]  bus_sel_o;
    logic         bus_ack_i;
    logic         bus_err_i;
    logic [255:0] bus_dat_i;
    logic         res_valid_o;
    logic         res_ready_i;
    logic [127:0] res_dat_o;
    logic         res_err_o;
    logic [5:0]   res_tag_o;

    int checkCount = 0;
    int errorCount = 0;

    logic [255:0] d0;
    logic [255:0] d1;

    any1_load_align #(.AWID(32), .TAGW(6)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_func_i  (req_func_i),
        .req_adr_i   (req_adr_i),
        .req_tag_i   (req_tag_i),
        .bus_cyc_o   (bus_cyc_o),
        .bus_adr_o   (bus_adr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_ack_i   (bus_ack_i),
        .bus_err_i   (bus_err_i),
        .bus_dat_i   (bus_dat_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_dat_o   (res_dat_o),
        .res_err_o   (res_err_o),
        .res_tag_o   (res_tag_o)
    );

    // 10 ns clock.
    always #5 clk_i = ~clk_i;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] func,
                                 input logic [31:0] adr, input logic [5:0] tag);
        req_valid_i = valid;
        req_func_i  = func;
        req_adr_i   = adr;
        req_tag_i   = tag;
    endtask

    task automatic driveBus(input logic ack, input logic err, input logic [255:0] dat);
        bus_ack_i = ack;
        bus_err_i = err;
        bus_dat_i = dat;
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic stepClk();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i       = 1'b1;
        res_ready_i = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0, 6'd0);
        driveBus(1'b0, 1'b0, '0);
        stepClk();
        stepClk();

        // Reset state.
        checkOutput("rst_req_ready", req_ready_o, 1);
        checkOutput("rst_bus_cyc",   bus_cyc_o, 0);
        checkOutput("rst_bus_adr",   bus_adr_o, 0);
        checkOutput("rst_bus_sel",   bus_sel_o, 0);
        checkOutput("rst_res_valid", res_valid_o, 0);
        checkOutput("rst_res_dat",   res_dat_o, 0);
        checkOutput("rst_res_err",   res_err_o, 0);
        checkOutput("rst_res_tag",   res_tag_o, 0);
        rst_i = 1'b0;
        stepClk();

        // Byte signed at 0x103, ack after three cycles of bus activity.
        d0 = {8{32'hDEADBEEF}};
        d0[31:24] = 8'h80;
        applyStimulus(1'b1, 4'b0000, 32'h103, 6'd5);
        stepClk();
        applyStimulus(1'b0, 4'd0, 32'd0, 6'd0);
        checkOutput("b_cyc1",      bus_cyc_o, 1);
        checkOutput("b_req_ready", req_ready_o, 0);
        checkOutput("b_adr",       bus_adr_o, 32'h100);
        checkOutput("b_sel",       bus_sel_o, 32'h0000_0008);
        stepClk();
        checkOutput("b_cyc2",      bus_cyc_o, 1);
        checkOutput("b_wait_val",  res_valid_o, 0);
        stepClk();
        driveBus(1'b1, 1'b0, d0);
        stepClk();
        driveBus(1'b0, 1'b0, '0);
        checkOutput("b_valid",     res_valid_o, 1);
        checkOutput("b_cyc_done",  bus_cyc_o, 0);
        checkOutput("b_dat",       res_dat_o, {{120{1'b1}}, 8'h80});
        checkOutput("b_err",       res_err_o, 0);
        checkOutput("b_tag",       res_tag_o, 6'd5);
        checkOutput("b_rdy_done",  req_ready_o, 0);
        res_ready_i = 1'b1;
        stepClk();
        res_ready_i = 1'b0;
        checkOutput("b_idle_val",  res_valid_o, 0);
        checkOutput("b_idle_rdy",  req_ready_o, 1);

        // Wyde unsigned at 0x21E, lanes 30-31.
        d0 = {8{32'h5A5A5A5A}};
        d0[255:240] = 16'h8001;
        applyStimulus(1'b1, 4'b1001, 32'h21E, 6'd9);
        stepClk();
        applyStimulus(1'b0, 4'd0, 32'd0, 6'd0);
        checkOutput("w_adr", bus_adr_o, 32'h200);
        checkOutput("w_sel", bus_sel_o, 32'hC000_0000);
        driveBus(1'b1, 1'b0, d0);
        stepClk();
        driveBus(1'b0, 1'b0, '0);
        checkOutput("w_valid", res_valid_o, 1);
        checkOutput("w_dat",   res_dat_o, 128'h8001);
        checkOutput("w_tag",   res_tag_o, 6'd9);
        res_ready_i = 1'b1;
        stepClk();
        res_ready_i = 1'b0;

        // Octa at 0x3C crossing into the next line.
        d0 = {8{32'hCAFEF00D}};
        d0[255:224] = 32'h44332211;
        d1 = {8{32'h0BADC0DE}};
        d1[31:0] = 32'h88776655;
        applyStimulus(1'b1, 4'b0011, 32'h3C, 6'd17);
        stepClk();
        applyStimulus(1'b0, 4'd0, 32'd0, 6'd0);
`ifdef ANY1_LDALIGN_SPLIT_EN
        checkOutput("o_cyc0", bus_cyc_o, 1);
        checkOutput("o_adr0", bus_adr_o, 32'h20);
        checkOutput("o_sel0", bus_sel_o, 32'hF000_0000);
        driveBus(1'b1, 1'b0, d0);
        stepClk();
        checkOutput("o_cyc1",   bus_cyc_o, 1);
        checkOutput("o_adr1",   bus_adr_o, 32'h40);
        checkOutput("o_sel1",   bus_sel_o, 32'h0000_000F);
        checkOutput("o_noval",  res_valid_o, 0);
        driveBus(1'b1, 1'b0, d1);
        stepClk();
        driveBus(1'b0, 1'b0, '0);
        checkOutput("o_valid", res_valid_o, 1);
        checkOutput("o_err",   res_err_o, 0);
        checkOutput("o_dat",   res_dat_o, {64'hFFFF_FFFF_FFFF_FFFF, 64'h8877665544332211});
`else
        checkOutput("o_nocyc", bus_cyc_o, 0);
        checkOutput("o_valid", res_valid_o, 1);
        checkOutput("o_err",   res_err_o, 1);
        checkOutput("o_dat",   res_dat_o, 0);
        driveBus(1'b1, 1'b0, d0);
        stepClk();
        driveBus(1'b0, 1'b0, '0);
        checkOutput("o_nocyc2", bus_cyc_o, 0);
`endif
        checkOutput("o_tag", res_tag_o, 6'd17);
        res_ready_i = 1'b1;
        stepClk();
        res_ready_i = 1'b0;

        // Byte unsigned in the last lane: exactly fills the line, one beat.
        d0 = {8{32'h5A5A5A5A}};
        d0[255:248] = 8'hA5;
        applyStimulus(1'b1, 4'b1000, 32'h1F, 6'd3);
        stepClk();
        applyStimulus(1'b0, 4'd0, 32'd0, 6'd0);
        checkOutput("e_adr", bus_adr_o, 32'h0);
        checkOutput("e_sel", bus_sel_o, 32'h8000_0000);
        driveBus(1'b1, 1'b0, d0);
        stepClk();
        driveBus(1'b0, 1'b0, '0);
        checkOutput("e_valid", res_valid_o, 1);
        checkOutput("e_dat",   res_dat_o, 128'hA5);
        res_ready_i = 1'b1;
        stepClk();
        res_ready_i = 1'b0;

        // Hexi marked unsigned: full width, extension flag has no effect.
        d0 = {128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0,
              128'h8123_4567_89AB_CDEF_0011_2233_4455_6677};
        applyStimulus(1'b1, 4'b1100, 32'h80, 6'd40);
        stepClk();
        applyStimulus(1'b0, 4'd0, 32'd0, 6'd0);
        checkOutput("h_sel", bus_sel_o, 32'h0000_FFFF);
        driveBus(1'b1, 1'b0, d0);
        stepClk();
        driveBus(1'b0, 1'b0, '0);
        checkOutput("h_dat", res_dat_o, 128'h8123_4567_89AB_CDEF_0011_2233_4455_6677);
        res_ready_i = 1'b1;
        stepClk();
        res_ready_i = 1'b0;

        // Tetra with ack and err together: error wins; then a 5-cycle stall.
        applyStimulus(1'b1, 4'b0010, 32'h48, 6'h2A);
        stepClk();
        applyStimulus(1'b0, 4'd0, 32'd0, 6'd0);
        checkOutput("t_sel", bus_sel_o, 32'h0000_0F00);
        driveBus(1'b1, 1'b1, {8{32'hFFFFFFFF}});
        stepClk();
        driveBus(1'b1, 1'b0, {8{32'h12345678}});
        applyStimulus(1'b1, 4'b0000, 32'h10, 6'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t_hold_val", res_valid_o, 1);
            checkOutput("t_hold_err", res_err_o, 1);
            checkOutput("t_hold_dat", res_dat_o, 0);
            checkOutput("t_hold_tag", res_tag_o, 6'h2A);
            checkOutput("t_hold_rdy", req_ready_o, 0);
            checkOutput("t_hold_cyc", bus_cyc_o, 0);
            stepClk();
        end
        driveBus(1'b0, 1'b0, '0);
        res_ready_i = 1'b1;
        stepClk();
        res_ready_i = 1'b0;
        checkOutput("t_no_b2b_cyc", bus_cyc_o, 0);
        checkOutput("t_no_b2b_rdy", req_ready_o, 1);
        applyStimulus(1'b0, 4'd0, 32'd0, 6'd0);
        stepClk();
        checkOutput("t_idle_cyc", bus_cyc_o, 0);

        // Illegal size code 6: immediate error, no bus cycle.
        applyStimulus(1'b1, 4'b0110, 32'h200, 6'd11);
        stepClk();
        applyStimulus(1'b0, 4'd0, 32'd0, 6'd0);
        checkOutput("s6_valid", res_valid_o, 1);
        checkOutput("s6_err",   res_err_o, 1);
        checkOutput("s6_cyc",   bus_cyc_o, 0);
        checkOutput("s6_tag",   res_tag_o, 6'd11);
        res_ready_i = 1'b1;
        stepClk();
        res_ready_i = 1'b0;

        // Reset while waiting in BEAT0: bus drops, no result appears.
        applyStimulus(1'b1, 4'b0010, 32'h300, 6'd7);
        stepClk();
        applyStimulus(1'b0, 4'd0, 32'd0, 6'd0);
        checkOutput("r_cyc_before", bus_cyc_o, 1);
        rst_i = 1'b1;
        stepClk();
        rst_i = 1'b0;
        checkOutput("r_cyc_after", bus_cyc_o, 0);
        checkOutput("r_valid",     res_valid_o, 0);
        checkOutput("r_ready",     req_ready_o, 1);
        driveBus(1'b1, 1'b0, {8{32'h77777777}});
        stepClk();
        driveBus(1'b0, 1'b0, '0);
        checkOutput("r_valid_late", res_valid_o, 0);
        checkOutput("r_cyc_late",   bus_cyc_o, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
